shift_seq_unit: RTL

Multi-cycle shift sequencer for the MIPS32 datapath. It executes SLL, SRL, SRA and ROTR by repeatedly applying a single-bit shift step to a working register, with one step per clock. A start/done handshake connects it to the multicycle control unit. It replaces a full barrel shifter where area matters more than latency, and sits beside the ALU, fed by rt and shamt.

---
 rtl/shift_seq_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle shift sequencer for SLL/SRL/SRA/ROTR.
// It applies one single-bit step per clock to a working register, so it
// costs shamt cycles instead of a barrel shifter. A start/done handshake
// connects it to the multicycle control unit.
module shift_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic [1:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic             accept;

    // A request is taken whenever no shift is running; start during SHIFT is dropped.
    assign accept = start && (state != SHIFT);

    // One-bit step of the working register for the latched operation.
    always_comb begin
        work_step = work;
        case (op_r)
            OP_SLL:  work_step = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  work_step = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  work_step = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_ROTR: work_step = {work[0], work[WIDTH-1:1]};
            default: work_step = work;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; shamt=0 goes straight to DONE, the last step (cnt=1) exits SHIFT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nx = (shamt == '0) ? DONE : SHIFT;
                else        state_nx = IDLE;
            end
            SHIFT:   if (cnt == SHW'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs; busy/done are flopped from the next state
    // so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            work <= '0;
            op_r <= OP_SLL;
            cnt  <= '0;
            y    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == SHIFT);
            done <= (state_nx == DONE);
            if (accept) begin
                work <= a;
                op_r <= op;
                cnt  <= shamt;
                if (shamt == '0) y <= a;
            end else if (state == SHIFT) begin
                work <= work_step;
                cnt  <= cnt - SHW'(1);
                if (cnt == SHW'(1)) y <= work_step;
            end
        end
    end

endmodule
